// File: rtl/rom_scan_sequencer.sv
// ROM scan sequencer: debounced manual stepping or auto dump over valid/ready.
// Optional ROM_SCAN_CHECKSUM_EN adds a 16-bit running sum of streamed words.
module rom_scan_sequencer #(
  parameter int unsigned          DATA_WIDTH      = 8,
  parameter int unsigned          ADDRESS_WIDTH   = 9,
  parameter int unsigned          CS_WIDTH        = 4,
  parameter logic [CS_WIDTH-1:0]  CS_ACTIVE       = CS_WIDTH'(1),
  parameter int unsigned          ACCESS_CYCLES   = 4,
  parameter int unsigned          DEBOUNCE_CYCLES = 250000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     increment_address,
  input  logic                     decrement_address,
  input  logic [ADDRESS_WIDTH-1:0] max_address,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [CS_WIDTH-1:0]      chip_select,
  output logic [DATA_WIDTH-1:0]    data_line,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     busy,
  output logic                     done
`ifdef ROM_SCAN_CHECKSUM_EN
  ,
  output logic [15:0]              checksum
`endif
);

  localparam int unsigned AccW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [AccW-1:0] AccLast = AccW'(ACCESS_CYCLES - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {StIdle, StSetup, StSample, StHandoff, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [AccW-1:0]          acc_q, acc_d;
  logic                     auto_q, auto_d;
  logic                     refresh_q, refresh_d;
  logic                     capture;

  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] btn_event;
  logic       inc_ev, dec_ev;

  assign btn_raw = {decrement_address, increment_address};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Counter saturates after the accepting sample so a held button never repeats.
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic [DbW-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset || !sync2_q[b]) begin
        cnt_q <= '0;
      end else if (cnt_q != DbMax) begin
        cnt_q <= cnt_q + DbW'(1);
      end
    end
    assign btn_event[b] = sync2_q[b] && (cnt_q == DbLast);
  end

  assign inc_ev = btn_event[0] && !btn_event[1];
  assign dec_ev = btn_event[1] && !btn_event[0];

  // State register; reset parks in IDLE with a pending display refresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      acc_q     <= '0;
      auto_q    <= 1'b0;
      refresh_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      auto_q    <= auto_d;
      refresh_q <= refresh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    acc_d     = '0;
    auto_d    = auto_q;
    refresh_d = refresh_q;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (refresh_q) begin
          refresh_d = 1'b0;
          auto_d    = 1'b0;
          state_d   = StSetup;
        end else if (mode) begin
          if (start) begin
            addr_d  = '0;
            auto_d  = 1'b1;
            state_d = StSetup;
          end
        end else if (inc_ev) begin
          addr_d  = (addr_q >= max_address) ? '0 : addr_q + ADDRESS_WIDTH'(1);
          auto_d  = 1'b0;
          state_d = StSetup;
        end else if (dec_ev) begin
          addr_d  = (addr_q == '0 || addr_q > max_address) ? max_address
                                                           : addr_q - ADDRESS_WIDTH'(1);
          auto_d  = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (acc_q == AccLast) begin
          state_d = StSample;
        end else begin
          acc_d = acc_q + AccW'(1);
        end
      end
      StSample: begin
        capture = 1'b1;
        state_d = auto_q ? StHandoff : StIdle;
      end
      StHandoff: begin
        if (data_ready) begin
          if (addr_q == max_address) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDRESS_WIDTH'(1);
            state_d = StSetup;
          end
        end
      end
      StDone: begin
        addr_d  = '0;
        auto_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    address_line = addr_q;
    chip_select  = '0;
    data_valid   = 1'b0;
    done         = 1'b0;
    busy         = (state_q != StIdle);
    unique case (state_q)
      StSetup, StSample: chip_select = CS_ACTIVE;
      StHandoff:         data_valid  = 1'b1;
      StDone:            done        = 1'b1;
      default:           ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_line <= '0;
      data_out  <= '0;
    end else if (capture) begin
      data_line <= data_line_in;
      data_out  <= data_line_in;
    end
  end

`ifdef ROM_SCAN_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        accept, clear_sum;

  assign accept    = (state_q == StHandoff) && data_ready;
  assign clear_sum = (state_q == StIdle) && !refresh_q && mode && start;
  assign checksum  = sum_q;

  always_ff @(posedge clk) begin
    if (reset || clear_sum) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + 16'(data_out);
    end
  end
`endif

endmodule

// File: tb/tb_rom_scan_sequencer.sv
// Directed bench for rom_scan_sequencer with a scoreboard on the scan stream.
// Define ROM_SCAN_CHECKSUM_EN to also cover the checksum output.
module tb_rom_scan_sequencer;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, mode, start, inc, dec, ready;
  logic [AW-1:0] max_address, address_line;
  logic [DW-1:0] data_line_in, data_line, data_out;
  logic [CW-1:0] chip_select;
  logic          data_valid, busy, done;
`ifdef ROM_SCAN_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  bit            rom_ones;
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  always_comb data_line_in = rom_ones ? 8'h01 : (address_line[7:0] ^ 8'hA5);

  rom_scan_sequencer #(
    .DATA_WIDTH      (DW),
    .ADDRESS_WIDTH   (AW),
    .CS_WIDTH        (CW),
    .CS_ACTIVE       (4'b0001),
    .ACCESS_CYCLES   (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mode              (mode),
    .start             (start),
    .increment_address (inc),
    .decrement_address (dec),
    .max_address       (max_address),
    .data_line_in      (data_line_in),
    .address_line      (address_line),
    .chip_select       (chip_select),
    .data_line         (data_line),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .data_ready        (ready),
    .busy              (busy),
    .done              (done)
`ifdef ROM_SCAN_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit i, input bit d, input int n);
    inc = i;
    dec = d;
    repeat (n) tick();
    inc = 1'b0;
    dec = 1'b0;
    repeat (15) tick();
  endtask

  task automatic run_scan(input logic [AW-1:0] maxa, input bit abuse, input int reset_word);
    int accepted = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int tail     = 0;
`ifdef ROM_SCAN_CHECKSUM_EN
    logic [15:0] sum = '0;
`endif
    max_address = maxa;
    mode        = 1'b1;
    sb.delete();
    for (int n = 0; n <= int'(maxa); n++) begin
      sb.push_back(rom_ones ? 8'h01 : (8'(n) ^ 8'hA5));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("scan_start_busy", busy, 1);
    check("scan_start_addr", address_line, 0);
    while (tail < 4 && cyc < 20000) begin
      ready = ($urandom_range(0, 1) == 1);
      if (abuse) begin
        inc   = (cyc >= 40 && cyc < 60);
        dec   = (cyc >= 500 && cyc < 520);
        mode  = (cyc >= 100 && cyc < 200) ? cyc[0] : 1'b1;
        start = (cyc == 300);
      end
      if (data_valid) check("cs_in_handoff", chip_select, 0);
      if (data_valid && ready) begin
        if (sb.size() == 0) begin
          check("extra_word_valid", data_valid, 0);
        end else begin
          check($sformatf("word%0d", accepted), data_out, sb.pop_front());
`ifdef ROM_SCAN_CHECKSUM_EN
          sum = sum + 16'(data_out);
`endif
        end
        accepted++;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_word", accepted, int'(maxa) + 1);
`ifdef ROM_SCAN_CHECKSUM_EN
        check("checksum_at_done", checksum, sum);
`endif
      end
      if (reset_word >= 0 && accepted == reset_word) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready = 1'b0;
        check("rst_valid", data_valid, 0);
        check("rst_addr", address_line, 0);
        check("rst_busy", busy, 0);
        check("rst_cs", chip_select, 0);
        repeat (6) tick();
        check("rst_refresh_busy", busy, 0);
        check("rst_refresh_data", data_line, 8'hA5);
        sb.delete();
        return;
      end
      if (done_cnt > 0) tail++;
      tick();
      cyc++;
    end
    inc   = 1'b0;
    dec   = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    check("done_count", done_cnt, 1);
    check("scan_end_busy", busy, 0);
    check("scan_end_addr", address_line, 0);
    check("scan_end_valid", data_valid, 0);
  endtask

  initial begin
    rom_ones    = 1'b0;
    reset       = 1'b1;
    mode        = 1'b0;
    start       = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    ready       = 1'b0;
    max_address = 9'd511;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_address_line", address_line, 0);
    check("rst_chip_select", chip_select, 0);
    check("rst_data_line", data_line, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("refresh_cs_setup", chip_select, 4'b0001);
      check("refresh_addr", address_line, 0);
    end
    tick();
    check("refresh_cs_sample", chip_select, 4'b0001);
    tick();
    check("refresh_data", data_line, 8'hA5);
    check("refresh_cs_off", chip_select, 0);
    check("refresh_idle", busy, 0);

    press(1'b1, 1'b0, 3);
    check("short_press_addr", address_line, 0);
    check("short_press_data", data_line, 8'hA5);
    press(1'b1, 1'b0, 10);
    check("inc_addr", address_line, 1);
    check("inc_data", data_line, 8'hA4);
    check("inc_idle", busy, 0);

    max_address = 9'd255;
    press(1'b0, 1'b1, 10);
    check("dec_to_zero", address_line, 0);
    press(1'b0, 1'b1, 10);
    check("dec_wrap_addr", address_line, 255);
    check("dec_wrap_data", data_line, 8'h5A);
    press(1'b1, 1'b0, 10);
    check("inc_wrap_addr", address_line, 0);
    check("inc_wrap_data", data_line, 8'hA5);
    press(1'b1, 1'b1, 10);
    check("both_addr", address_line, 0);
    check("both_busy", busy, 0);

    run_scan(9'd511, 1'b1, -1);
    run_scan(9'd511, 1'b0, 100);

`ifdef ROM_SCAN_CHECKSUM_EN
    rom_ones = 1'b1;
    run_scan(9'd255, 1'b0, -1);
    check("checksum_ones", checksum, 16'h0100);
    rom_ones = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
